count_seek_ctrl: RTL and testbench

Controller that owns the control inputs of the mod-12 loadable up/down counter and shares it between two requesters. Each requester asks for the counter to be driven to a target value. The block arbitrates round-robin, steps the counter along the shorter modular path, and acknowledges on arrival. Between operations it freezes the counter by reloading the held value every cycle, because the counter has no enable.

---
 rtl/count_seek_pkg.sv | 15 +
 rtl/count_seek_ctrl_mod_dist.sv | 22 ++
 rtl/count_seek_ctrl.sv | 127 ++++++++++++
 tb/tb_count_seek_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/count_seek_pkg.sv
// Shared constants and types for the mod-12 counter seek controller.
package count_seek_pkg;
  localparam int unsigned CNT_MOD = 12;
  localparam int unsigned W       = 4;
  localparam int unsigned MAX_V   = CNT_MOD - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    REJ  = 2'd2
  } state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;
endpackage

// File: rtl/count_seek_ctrl_mod_dist.sv
// Modular distance from cur to tgt and the direction of the shorter path.
module mod_dist #(
  parameter int unsigned CNT_MOD = 12,
  parameter int unsigned W       = 4
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  output logic [W:0]   d,
  output logic         dir
);
  import count_seek_pkg::*;

  logic [W:0] diff;

  always_comb begin
    diff = {1'b0, tgt} - {1'b0, cur};
    // MSB set means tgt < cur; fold back into 0..CNT_MOD-1
    if (diff[W]) d = diff + (W+1)'(CNT_MOD);
    else         d = diff;
    dir = (d > (W+1)'(CNT_MOD / 2)) ? DIR_DN : DIR_UP;
  end
endmodule

// File: rtl/count_seek_ctrl.sv
// Round-robin seek controller driving the control inputs of a mod-12
// loadable up/down counter on behalf of two requesters.
module count_seek_ctrl #(
  parameter int unsigned CNT_MOD = 12,
  parameter int unsigned W       = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] tgt0,
  input  logic [W-1:0] tgt1,
  output logic         ack0,
  output logic         ack1,
  output logic         err0,
  output logic         err1,
  output logic         busy,
  input  logic [W-1:0] cnt_q,
  output logic         load_in,
  output logic [W-1:0] data_in,
  output logic         up_down
);
  import count_seek_pkg::*;

  state_t       state, state_n;
  logic         gnt, gnt_n;
  logic [W-1:0] tgt_q, tgt_n;
  logic         dir_q, dir_n;
  logic [W-1:0] hold_q, hold_n;
  logic         last_gnt, last_n;

  logic         pick;
  logic [W-1:0] sel_tgt;
  logic         req_g;
  logic         ack_g, err_g;
  logic [W:0]   dist_d;
  logic         dist_dir;

  assign pick    = (req0 & req1) ? ~last_gnt : req1;
  assign sel_tgt = pick ? tgt1 : tgt0;
  assign req_g   = gnt ? req1 : req0;

  mod_dist #(.CNT_MOD(CNT_MOD), .W(W)) u_dist (
    .cur (cnt_q),
    .tgt (sel_tgt),
    .d   (dist_d),
    .dir (dist_dir)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      tgt_q    <= '0;
      dir_q    <= DIR_UP;
      hold_q   <= '0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      tgt_q    <= tgt_n;
      dir_q    <= dir_n;
      hold_q   <= hold_n;
      last_gnt <= last_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    tgt_n   = tgt_q;
    dir_n   = dir_q;
    hold_n  = hold_q;
    last_n  = last_gnt;
    load_in = 1'b1;
    data_in = hold_q;
    up_down = DIR_UP;
    busy    = 1'b0;
    ack_g   = 1'b0;
    err_g   = 1'b0;

    case (state)
      IDLE: begin
        if (req0 | req1) begin
          gnt_n  = pick;
          last_n = pick;
          tgt_n  = sel_tgt;
          if (32'(sel_tgt) >= CNT_MOD) begin
            state_n = REJ;
          end else begin
            dir_n   = (dist_d == '0) ? DIR_UP : dist_dir;
            state_n = SEEK;
          end
        end
      end
      SEEK: begin
        busy = 1'b1;
        if (cnt_q == tgt_q) begin
          data_in = tgt_q;
          ack_g   = 1'b1;
          hold_n  = tgt_q;
          state_n = IDLE;
        end else if (!req_g) begin
          data_in = cnt_q;
          hold_n  = cnt_q;
          state_n = IDLE;
        end else begin
          load_in = 1'b0;
          up_down = dir_q;
        end
      end
      REJ: begin
        busy    = 1'b1;
        ack_g   = 1'b1;
        err_g   = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Masked during rst so an in-flight seek never completes while resetting.
  assign ack0 = ack_g & ~gnt & ~rst;
  assign ack1 = ack_g &  gnt & ~rst;
  assign err0 = err_g & ~gnt & ~rst;
  assign err1 = err_g &  gnt & ~rst;
endmodule

// File: tb/tb_count_seek_ctrl.sv
// Scoreboard bench for count_seek_ctrl with a behavioural mod-12 counter.
module tb_count_seek_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [3:0] tgt0 = '0, tgt1 = '0;
  logic       ack0, ack1, err0, err1, busy;
  logic [3:0] cnt_q;
  logic       load_in;
  logic [3:0] data_in;
  logic       up_down;

  count_seek_ctrl #(.CNT_MOD(12), .W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .tgt0(tgt0), .tgt1(tgt1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .busy(busy), .cnt_q(cnt_q),
    .load_in(load_in), .data_in(data_in), .up_down(up_down)
  );

  always #5 clk = ~clk;

  // Behavioural mod-12 counter owned by the controller.
  always @(posedge clk) begin
    if (rst)            cnt_q <= 4'd0;
    else if (load_in)   cnt_q <= data_in;
    else if (up_down)   cnt_q <= (cnt_q == 4'd0)  ? 4'd11 : cnt_q - 4'd1;
    else                cnt_q <= (cnt_q == 4'd11) ? 4'd0  : cnt_q + 4'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] flags;  // {ack0, ack1, err0, err1}
    logic [3:0] cnt;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  bit   saw2;
  int   n_up, n_dn;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (ack0 | ack1 | err0 | err1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", int'({ack0, ack1, err0, err1}), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("ack_flags", int'({ack0, ack1, err0, err1}), int'(mon_e.flags));
        chk("ack_cnt",   int'(cnt_q), int'(mon_e.cnt));
        chk("ack_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // One request: expected ack d cycles after the first SEEK cycle, d steps in dir.
  task automatic do_req(input bit id, input logic [3:0] t, input int d,
                        input bit dir, input bit e, input logic [3:0] c);
    exp_t x;
    bit   done;
    @(negedge clk); #2;
    if (id) begin req1 = 1'b1; tgt1 = t; end
    else    begin req0 = 1'b1; tgt0 = t; end
    x.flags = {~id, id, e & ~id, e & id};
    x.cnt   = c;
    x.cyc   = cyc + 1 + d;
    sb.push_back(x);
    done = 1'b0; saw2 = 1'b0; n_up = 0; n_dn = 0;
    for (int i = 0; i < 30 && !done; i++) begin
      @(negedge clk);
      if (cnt_q == 4'd2) saw2 = 1'b1;
      if (!load_in) begin
        if (up_down) n_dn++;
        else         n_up++;
      end
      if (id ? ack1 : ack0) done = 1'b1;
    end
    #2;
    if (id) req1 = 1'b0; else req0 = 1'b0;
    if (!done) chk("ack_timeout", 0, 1);
    chk("steps_up", n_up, dir ? 0 : d);
    chk("steps_dn", n_dn, dir ? d : 0);
  endtask

  initial begin : stim
    int  c0;
    bit  d0, d1;

    // Reset and 20 idle cycles: counter frozen at 0
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_cnt",  int'(cnt_q), 0);
      chk("idle_load", int'(load_in), 1);
      chk("idle_data", int'(data_in), 0);
      chk("idle_busy", int'(busy), 0);
    end

    // 0 -> 3 up, then holds
    do_req(1'b0, 4'd3, 3, 1'b0, 1'b0, 4'd3);
    step(10);
    chk("hold_after_3", int'(cnt_q), 3);

    // 3 -> 1 down, then 1 -> 10 down through 0/11, never touching 2
    do_req(1'b1, 4'd1, 2, 1'b1, 1'b0, 4'd1);
    do_req(1'b1, 4'd10, 3, 1'b1, 1'b0, 4'd10);
    chk("no_pass_2", int'(saw2), 0);

    // 10 -> 0 up, then tie cases 0 -> 6 and 6 -> 0 both go up
    do_req(1'b0, 4'd0, 2, 1'b0, 1'b0, 4'd0);
    do_req(1'b0, 4'd6, 6, 1'b0, 1'b0, 4'd6);
    do_req(1'b1, 4'd0, 6, 1'b0, 1'b0, 4'd0);

    // Both requesting after reset: 0 first to 5, then 1 down to 2
    do_reset();
    @(negedge clk); #2;
    req0 = 1'b1; tgt0 = 4'd5;
    req1 = 1'b1; tgt1 = 4'd2;
    c0 = cyc;
    sb.push_back('{flags: 4'b1000, cnt: 4'd5, cyc: c0 + 6});
    sb.push_back('{flags: 4'b0100, cnt: 4'd2, cyc: c0 + 11});
    d0 = 1'b0; d1 = 1'b0;
    for (int i = 0; i < 40 && !(d0 && d1); i++) begin
      @(negedge clk);
      if (ack0) d0 = 1'b1;
      if (ack1) d1 = 1'b1;
      #2;
      if (d0) req0 = 1'b0;
      if (d1) req1 = 1'b0;
    end
    chk("both_done", int'({d0, d1}), 3);
    req0 = 1'b0; req1 = 1'b0;

    // Illegal targets: ack+err one cycle later, counter untouched
    do_req(1'b0, 4'd12, 0, 1'b0, 1'b1, 4'd2);
    do_req(1'b1, 4'd15, 0, 1'b0, 1'b1, 4'd2);
    step(3);
    chk("rej_hold", int'(cnt_q), 2);

    // Abort: 0 -> 9 goes down, dropped once counter shows 10
    do_reset();
    @(negedge clk); #2;
    req0 = 1'b1; tgt0 = 4'd9;
    step(3);
    chk("abort_cnt_before", int'(cnt_q), 10);
    chk("abort_busy", int'(busy), 1);
    #2 req0 = 1'b0;
    step(1);
    chk("abort_cnt", int'(cnt_q), 10);
    chk("abort_load", int'(load_in), 1);
    chk("abort_hold", int'(data_in), 10);
    step(5);
    chk("abort_cnt_late", int'(cnt_q), 10);
    chk("abort_hold_late", int'(data_in), 10);

    // Reset in the middle of a 10 -> 4 seek
    @(negedge clk); #2;
    req0 = 1'b1; tgt0 = 4'd4;
    step(2);
    chk("mid_seek_cnt", int'(cnt_q), 11);
    #2 rst = 1'b1; req0 = 1'b0;
    step(1);
    chk("rst_cnt",  int'(cnt_q), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_load", int'(load_in), 1);
    chk("rst_data", int'(data_in), 0);
    #2 rst = 1'b0;

    // 0 -> 11: one step down across the wrap
    do_req(1'b1, 4'd11, 1, 1'b1, 1'b0, 4'd11);

    step(3);
    chk("queue_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
